reg4_write_arbiter: RTL

Shares write access to the four 8-bit result registers `a`, `b`, `c`, `d` among `NUM_REQ` requesters. Arbitration is round-robin, and a requester can lock the grant across consecutive beats. Each beat either overwrites or accumulates into one register. The block sits between the generated sequencing logic and the observable `a`..`d` outputs of `top`, and is the single write port to them.

---
 rtl/reg4_arb_pkg.sv | 22 ++
 rtl/reg4_write_arbiter_rr_pick.sv | 32 +++
 rtl/reg4_write_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reg4_arb_pkg.sv
// Shared types and constants for the four-register write arbiter.
package reg4_arb_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_ADD   = 1'b1
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;

endpackage

// File: rtl/reg4_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// at or after ptr (wrapping modulo N), plus a valid flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    idx  = '0;
    vld  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg4_write_arbiter.sv
// Single write port onto result registers a..d, shared by NUM_REQ
// requesters with round-robin arbitration and optional grant locking.
// Build option: REG4_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module reg4_write_arbiter
  import reg4_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*2-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         a,
  output logic [DATA_W-1:0]         b,
  output logic [DATA_W-1:0]         c,
  output logic [DATA_W-1:0]         d,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Accumulate wraps modulo 2^DATA_W; the carry is dropped.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return x + y;
  endfunction

  arb_state_e        state, next_state;
  logic [IDX_W-1:0]  owner, next_owner;
  logic [IDX_W-1:0]  pick_ptr, pick_idx, gidx;
  logic              pick_vld, commit;

  logic [1:0]        sel_addr;
  op_e               sel_op;
  logic [DATA_W-1:0] sel_data, cur_val, wr_val;
  logic [DATA_W-1:0] regs [NUM_REGS];

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef REG4_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [IDX_W-1:0] rr_ptr;
  logic             ptr_upd;

  // In LOCKED gidx is the owner, so any beat or release lands on owner+1.
  assign ptr_upd = commit || (state == ST_LOCKED);

  // Round-robin pointer advances past whoever was last served.
  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= '0;
    else if (ptr_upd) rr_ptr <= ptr_inc(gidx);
  end

  assign pick_ptr = rr_ptr;
`endif

  // Arbitration FSM state and lock owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= next_state;
      owner <= next_owner;
    end
  end

  // Grant selection; reset suppresses any commit in the same cycle.
  always_comb begin
    next_state = state;
    next_owner = owner;
    commit     = 1'b0;
    gidx       = owner;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            commit = 1'b1;
            gidx   = pick_idx;
            if (req_lock[pick_idx]) begin
              next_state = ST_LOCKED;
              next_owner = pick_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (req[owner]) begin
            commit = 1'b1;
            if (!req_lock[owner]) next_state = ST_IDLE;
          end else begin
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Steer the granted requester's operand and compute the new value.
  always_comb begin
    sel_addr = '0;
    sel_op   = OP_WRITE;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        sel_addr = req_addr[2*i +: 2];
        sel_op   = op_e'(req_op[i]);
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
    cur_val = regs[sel_addr];
    wr_val  = (sel_op == OP_ADD) ? add_wrap(cur_val, sel_data) : sel_data;
  end

  // Result registers: only the addressed one changes on a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit) begin
      regs[sel_addr] <= wr_val;
    end
  end

  assign ack  = commit ? (NUM_REQ'(1) << gidx) : '0;
  assign busy = (state == ST_LOCKED);
  assign a    = regs[REG_A];
  assign b    = regs[REG_B];
  assign c    = regs[REG_C];
  assign d    = regs[REG_D];

endmodule
